m68k_bus_target: RTL and testbench
==================================

M68K_BUS_TARGET -- requirements
Module: m68k_bus_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hE9, the value A[23:16] must equal for the block to respond.
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0..7, the extra clocks inserted before DTACK.
REQ-003 SHALL have parameter ID_VALUE, default 16'h5053, the constant returned by register 7.
REQ-004 SHALL use one clock and an asynchronous active-low reset, as the ports below.
REQ-005 M68K_CLK  in  1  68000 bus clock (7 MHz); all state updates on its rising edge.
REQ-006 M68K_RESET_n  in  1  asynchronous active-low reset.
REQ-007 M68K_A  in  23  address bus A[23:1].
REQ-008 M68K_D  inout  16  data bus; driven only while responding to a read.
REQ-009 M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW  in  1 each  bus strobes and direction (RW=1 read).
REQ-010 M68K_DTACK_n  out  1  tristate acknowledge; low = ack, high for one clock on release, otherwise Z.
REQ-011 BUSY  out  1  high while the state machine is outside IDLE.

Function
REQ-012 SHALL register AS_n, UDS_n, LDS_n, RW, A[23:1] and D once on each rising edge; all decisions use these registered copies.
REQ-013 SHALL implement states IDLE, WAIT, ACK, RELEASE; BUSY=1 in every state except IDLE.
REQ-014 IDLE->WAIT when registered AS_n=0, at least one DS_n=0 and A[23:16]==BASE_ADDR; the wait counter loads WAIT_STATES.
REQ-015 WAIT: counter decrements each clock; on counter==0 go to ACK; with WAIT_STATES=0 the first WAIT clock goes straight to ACK.
REQ-016 DTACK_n SHALL go low exactly WAIT_STATES+2 rising edges after the edge at which AS_n low was first present on the pins.
REQ-017 Register index = A[3:1] (8 x 16-bit); A[15:4] ignored (registers alias within the 64 KB window).
REQ-018 Read: M68K_D SHALL be driven from the edge entering WAIT until the edge at which registered AS_n=1 is seen; data SHALL be the register value sampled on entry to WAIT.
REQ-019 Write: captured on the edge entering ACK; UDS_n=0 updates bits 15:8, LDS_n=0 updates bits 7:0, both update the whole word.
REQ-020 Registers 0..5 are read/write scratch.
REQ-021 Register 6 is a 16-bit access counter: +1, wrapping FFFF->0000, on every access reaching ACK.
REQ-022 Register 6 read SHALL return the value before that access's increment.
REQ-023 Register 6 write SHALL load the written byte lanes and suppress the increment for that access.
REQ-024 Register 7 returns ID_VALUE; writes to it are ignored, but the access still gets DTACK and increments register 6.
REQ-025 ACK: DTACK_n held low until registered AS_n=1, then go to RELEASE.
REQ-026 RELEASE: DTACK_n driven high for exactly one clock, then Z; M68K_D Z; return to IDLE.
REQ-027 AS_n sampled high while in WAIT (aborted cycle) SHALL go to RELEASE with no write, no counter increment and no DTACK low.
REQ-028 A new cycle SHALL NOT be accepted in RELEASE; the earliest acceptance is the edge after returning to IDLE.
REQ-029 Accesses with A[23:16]!=BASE_ADDR SHALL leave M68K_D and M68K_DTACK_n at Z and the state in IDLE.
REQ-030 A cycle with AS_n low and both DS_n high SHALL NOT be accepted until a DS goes low while AS_n is still low.

Reset
REQ-031 While M68K_RESET_n=0: state IDLE, BUSY=0, M68K_DTACK_n=Z, M68K_D=Z, registers 0..6 = 16'h0000, wait counter 0, registered strobes = 1.
REQ-032 Reset asserted mid-cycle SHALL release DTACK_n and D to Z immediately (asynchronously), with no partial write.

Verification
REQ-033 Word write 16'hA55A to 0xE90002 with WAIT_STATES=2 -> DTACK_n low 4 edges after AS_n fall; a read of 0xE90002 then returns A55A; register 6 = 0002.
REQ-034 Byte write with only LDS_n=0, data 0x12, to register 3 already holding 16'hFFFF -> register 3 = 16'hFF12.
REQ-035 Read register 7 -> 16'h5053; a write of 16'h0000 to it -> register 7 still reads 5053 and register 6 has incremented.
REQ-036 Write 16'hFFFF to register 6, then one read of register 0 -> register 6 reads 0000 (wrap), and the read of register 6 itself returns 0000.
REQ-037 AS_n low for 2 clocks then high, WAIT_STATES=4 -> no DTACK low, DTACK_n high for 1 clock, no register change; access to 0xE80000 -> bus stays Z.
REQ-038 Reset pulse during ACK -> DTACK_n and D go Z within the reset pulse, BUSY=0, registers 0..6 = 0000.

Source files
------------

// File: rtl/m68k_bus_target.sv
// 68000 bus target: eight 16-bit registers in a 64 KB window, programmable wait states,
// tristate DTACK/data with a one-clock high drive on DTACK release.
module m68k_bus_target #(
    parameter logic [7:0]  BASE_ADDR   = 8'hE9,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] ID_VALUE    = 16'h5053
) (
    input  logic        M68K_CLK,
    input  logic        M68K_RESET_n,
    input  logic [23:1] M68K_A,
    inout  wire  [15:0] M68K_D,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    output wire         M68K_DTACK_n,
    output logic        BUSY
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    logic        as_reg, uds_reg, lds_reg, rw_reg;
    logic [23:1] a_reg;
    logic [15:0] d_reg;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic [2:0]  idx_reg;
    logic        rw_cyc_reg;
    logic [15:0] rdata_reg;
    logic        d_oe_reg;
    logic        dtack_oe_reg;
    logic        dtack_val_reg;
    logic        busy_reg;

    logic [15:0] scratch_reg [0:5];
    logic [15:0] acc_cnt_reg;

    logic [15:0] read_mux;
    logic        accept;
    logic        reach_ack;
    logic        do_write;
    logic        unused_addr_bits;

    // A[15:4] only alias the register file and are deliberately not decoded.
    assign unused_addr_bits = ^a_reg[15:4];

    function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                                input logic [15:0] new_val,
                                                input logic        u_n,
                                                input logic        l_n);
        return {u_n ? old_val[15:8] : new_val[15:8],
                l_n ? old_val[7:0]  : new_val[7:0]};
    endfunction

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            as_reg  <= 1'b1;
            uds_reg <= 1'b1;
            lds_reg <= 1'b1;
            rw_reg  <= 1'b1;
            a_reg   <= '0;
            d_reg   <= '0;
        end else begin
            as_reg  <= M68K_AS_n;
            uds_reg <= M68K_UDS_n;
            lds_reg <= M68K_LDS_n;
            rw_reg  <= M68K_RW;
            a_reg   <= M68K_A;
            d_reg   <= M68K_D;
        end
    end

    always_comb begin
        read_mux = ID_VALUE;
        case (a_reg[3:1])
            3'd6:    read_mux = acc_cnt_reg;
            3'd7:    read_mux = ID_VALUE;
            default: read_mux = scratch_reg[a_reg[3:1]];
        endcase
    end

    assign accept    = !as_reg && (!uds_reg || !lds_reg) && (a_reg[23:16] == BASE_ADDR);
    assign reach_ack = (state_reg == S_WAIT) && !as_reg && (cnt_reg == 3'd0);
    assign do_write  = reach_ack && !rw_cyc_reg;

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            rw_cyc_reg    <= 1'b1;
            rdata_reg     <= '0;
            d_oe_reg      <= 1'b0;
            dtack_oe_reg  <= 1'b0;
            dtack_val_reg <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg  <= S_WAIT;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= WS;
                        idx_reg    <= a_reg[3:1];
                        rw_cyc_reg <= rw_reg;
                        rdata_reg  <= read_mux;
                        d_oe_reg   <= rw_reg;
                    end
                end
                S_WAIT: begin
                    if (as_reg) begin
                        // Master gave up before we acknowledged: release without DTACK low.
                        state_reg     <= S_RELEASE;
                        d_oe_reg      <= 1'b0;
                        dtack_oe_reg  <= 1'b1;
                        dtack_val_reg <= 1'b1;
                    end else if (cnt_reg == 3'd0) begin
                        state_reg     <= S_ACK;
                        dtack_oe_reg  <= 1'b1;
                        dtack_val_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                S_ACK: begin
                    if (as_reg) begin
                        state_reg     <= S_RELEASE;
                        d_oe_reg      <= 1'b0;
                        dtack_val_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    busy_reg      <= 1'b0;
                    dtack_oe_reg  <= 1'b0;
                    dtack_val_reg <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            for (int i = 0; i < 6; i++) scratch_reg[i] <= '0;
            acc_cnt_reg <= '0;
        end else begin
            if (do_write && idx_reg < 3'd6)
                scratch_reg[idx_reg] <= merge_lanes(scratch_reg[idx_reg], d_reg, uds_reg, lds_reg);
            // A write to the counter itself replaces that access's increment.
            if (reach_ack) begin
                if (do_write && idx_reg == 3'd6)
                    acc_cnt_reg <= merge_lanes(acc_cnt_reg, d_reg, uds_reg, lds_reg);
                else
                    acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
        end
    end

    assign M68K_D       = d_oe_reg     ? rdata_reg     : 16'hzzzz;
    assign M68K_DTACK_n = dtack_oe_reg ? dtack_val_reg : 1'bz;
    assign BUSY         = busy_reg;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: vector table of bus cycles plus hand sequences
// for abort, address miss, late data strobe and reset during ACK. Pulls expose Z as 1.
module tb_m68k_bus_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:1] a = '0;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
    logic [15:0] tb_d = '0;
    logic        tb_d_oe = 1'b0;
    tri1  [15:0] d_bus;
    tri1         dtack_n;
    wire         busy;

    assign d_bus = tb_d_oe ? tb_d : 16'hzzzz;

    always #5 clk = ~clk;

    m68k_bus_target #(.BASE_ADDR(8'hE9), .WAIT_STATES(2), .ID_VALUE(16'h5053)) dut (
        .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_D(d_bus),
        .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .M68K_DTACK_n(dtack_n), .BUSY(busy)
    );

    typedef struct {
        string       name;
        logic [23:0] addr;
        logic        rd;
        logic        u_n;
        logic        l_n;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [23:0] ad, input logic rd,
                                input logic u, input logic l, input logic [15:0] wd,
                                input logic [15:0] ex);
        vec_t v;
        v.name = n; v.addr = ad; v.rd = rd; v.u_n = u; v.l_n = l; v.wd = wd; v.exp = ex;
        return v;
    endfunction

    // Drops the strobes after DTACK and checks the ACK->RELEASE->IDLE tail.
    task automatic end_cycle(input string name);
        int rel;
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
        rel = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); rel++; #1;
            if (!busy) break;
        end
        check({name, "_release_clocks"}, rel, 3);
        check({name, "_dtack_idle"}, dtack_n, 1'b1);
    endtask

    // Waits (bounded) for DTACK low; lat counts edges after the first edge the strobe is seen.
    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); lat++; #1;
            if (dtack_n === 1'b0) break;
        end
        if (dtack_n !== 1'b0) lat = 99;
    endtask

    task automatic do_vec(input vec_t v);
        int lat;
        logic [15:0] rdata;
        @(posedge clk); #1;
        a = v.addr[23:1]; rw = v.rd; uds_n = v.u_n; lds_n = v.l_n;
        tb_d = v.wd; tb_d_oe = !v.rd; as_n = 1'b0;
        wait_ack(lat);
        rdata = d_bus;
        $display("%s %s addr=%06h data=%04h dtack_edges=%0d", v.name, v.rd ? "RD" : "WR",
                 v.addr, v.rd ? rdata : v.wd, lat);
        check({v.name, "_latency"}, lat, 4);
        if (v.rd) check({v.name, "_rdata"}, rdata, v.exp);
        end_cycle(v.name);
    endtask

    vec_t vt[20];

    initial begin
        int lat;
        int busy_n;
        bit seen_low, seen_busy, seen_drive;

        vt[0]  = mk("w_r1",        24'hE90002, 1'b0, 1'b0, 1'b0, 16'hA55A, 16'h0000);
        vt[1]  = mk("r_r1",        24'hE90002, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA55A);
        vt[2]  = mk("r_cnt_2",     24'hE9000C, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002);
        vt[3]  = mk("w_r3_ffff",   24'hE90006, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        vt[4]  = mk("w_r3_lo",     24'hE90006, 1'b0, 1'b1, 1'b0, 16'hAB12, 16'h0000);
        vt[5]  = mk("r_r3_ff12",   24'hE90006, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFF12);
        vt[6]  = mk("w_r3_hi",     24'hE90006, 1'b0, 1'b0, 1'b1, 16'h34CD, 16'h0000);
        vt[7]  = mk("r_r3_3412",   24'hE90006, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3412);
        vt[8]  = mk("r_id",        24'hE9000E, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5053);
        vt[9]  = mk("w_id",        24'hE9000E, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        vt[10] = mk("r_id_again",  24'hE9000E, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5053);
        vt[11] = mk("r_cnt_b",     24'hE9000C, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h000B);
        vt[12] = mk("w_cnt_ffff",  24'hE9000C, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        vt[13] = mk("r_r0",        24'hE90000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        vt[14] = mk("r_cnt_wrap",  24'hE9000C, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        vt[15] = mk("r_alias_r1",  24'hE9F012, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA55A);
        vt[16] = mk("w_cnt_lo",    24'hE9000C, 1'b0, 1'b1, 1'b0, 16'h7705, 16'h0000);
        vt[17] = mk("r_cnt_5",     24'hE9000C, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005);
        vt[18] = mk("w_r5",        24'hE9000A, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
        vt[19] = mk("r_r5",        24'hE9000A, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_dtack_z", dtack_n, 1'b1);
        check("rst_d_z", d_bus, 16'hFFFF);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 20; i++) do_vec(vt[i]);

        // Aborted write: AS low for two edges only
        @(posedge clk); #1;
        a = 23'(24'hE90000 >> 1); rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        tb_d = 16'hBEEF; tb_d_oe = 1'b1; as_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
        seen_low = 1'b0; busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dtack_n === 1'b0) seen_low = 1'b1;
            if (busy) busy_n++;
        end
        $display("abort WR addr=e90000 busy_clocks=%0d dtack_low=%0d", busy_n, seen_low);
        check("abort_no_dtack_low", seen_low, 1'b0);
        check("abort_busy_clocks", busy_n, 3);
        do_vec(mk("r_r0_after_abort", 24'hE90000, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000));
        do_vec(mk("r_cnt_9",          24'hE9000C, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0009));

        // Address outside the window: no response at all
        @(posedge clk); #1;
        a = 23'(24'hE80000 >> 1); rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        seen_low = 1'b0; seen_busy = 1'b0; seen_drive = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dtack_n === 1'b0) seen_low = 1'b1;
            if (busy) seen_busy = 1'b1;
            if (d_bus !== 16'hFFFF) seen_drive = 1'b1;
        end
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        $display("miss RD addr=e80000 busy=%0d dtack_low=%0d d_driven=%0d", seen_busy, seen_low, seen_drive);
        check("miss_busy", seen_busy, 1'b0);
        check("miss_dtack", seen_low, 1'b0);
        check("miss_d_z", seen_drive, 1'b0);

        // AS low with both data strobes high, LDS arrives later
        @(posedge clk); #1;
        a = 23'(24'hE9000C >> 1); rw = 1'b1; as_n = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("late_ds_not_accepted", seen_busy, 1'b0);
        @(posedge clk); #1; lds_n = 1'b0;
        wait_ack(lat);
        $display("late_ds RD addr=e9000c data=%04h dtack_edges=%0d", d_bus, lat);
        check("late_ds_latency", lat, 4);
        check("late_ds_rdata", d_bus, 16'h000A);
        end_cycle("late_ds");

        // Reset pulse while in ACK on a read
        @(posedge clk); #1;
        a = 23'(24'hE90002 >> 1); rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        wait_ack(lat);
        check("rst_ack_latency", lat, 4);
        check("rst_ack_rdata", d_bus, 16'hA55A);
        #2 rst_n = 1'b0;
        #1;
        $display("reset_in_ack dtack=%0b d=%04h busy=%0b", dtack_n, d_bus, busy);
        check("rst_ack_dtack_z", dtack_n, 1'b1);
        check("rst_ack_d_z", d_bus, 16'hFFFF);
        check("rst_ack_busy", busy, 1'b0);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        do_vec(mk("r_cnt_after_rst", 24'hE9000C, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000));
        do_vec(mk("r_r1_after_rst",  24'hE90002, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000));
        do_vec(mk("r_r3_after_rst",  24'hE90006, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
